// File: rtl/run_serializer.sv
// run_serializer: turns queued (bit, run-length) tokens into a serial bit
// stream with a per-bit enable, plus reference run flags (exp_run2/exp_run3)
// aligned with each emitted bit for comparison against a run detector.
//
// Handshake: a token transfers on a rising clk edge where in_valid && in_ready.
// in_ready depends only on registered FIFO pointers, never on in_valid.
// Zero-length tokens complete the handshake but are dropped, never stored.
module run_serializer #(
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [LEN_W-1:0] in_len,
  input  logic             stall,
  output logic             dout,
  output logic             cen,
  output logic             run_done,
  output logic             exp_run2,
  output logic             exp_run3,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  // FIFO storage: {bit, len}
  logic [LEN_W:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  logic             head_bit;
  logic [LEN_W-1:0] head_len;

  // Emission FSM
  state_t           state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic             cur_bit, cur_bit_n;
  logic             emit, emit_bit, last;

  // History of consecutive equal emitted bits (0 = nothing emitted yet)
  logic [1:0]       hcnt, hcnt_n;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full && (in_len != '0);
  assign head_bit   = mem[rptr[AW-1:0]][LEN_W];
  assign head_len   = mem[rptr[AW-1:0]][LEN_W-1:0];

  // Next-state logic: pop tokens, pick the bit to emit, count down the run.
  // Popping from IDLE emits the token's first bit immediately; popping on the
  // last bit of a run loads the whole next token so its first bit follows
  // on the very next cycle with no bubble.
  always_comb begin
    state_n   = state;
    rem_n     = rem;
    cur_bit_n = cur_bit;
    pop       = 1'b0;
    emit      = 1'b0;
    emit_bit  = cur_bit;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && !stall) begin
          pop      = 1'b1;
          emit     = 1'b1;
          emit_bit = head_bit;
          if (head_len == LEN_W'(1)) begin
            last = 1'b1;
          end else begin
            state_n   = S_EMIT;
            rem_n     = head_len - LEN_W'(1);
            cur_bit_n = head_bit;
          end
        end
      end
      S_EMIT: begin
        if (!stall) begin
          emit     = 1'b1;
          emit_bit = cur_bit;
          if (rem == LEN_W'(1)) begin
            last = 1'b1;
            if (!fifo_empty) begin
              pop       = 1'b1;
              cur_bit_n = head_bit;
              rem_n     = head_len;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            rem_n = rem - LEN_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // History counter: restart at 1 on a bit change, saturate at 3.
  always_comb begin
    hcnt_n = hcnt;
    if (hcnt == 2'd0 || emit_bit != dout) begin
      hcnt_n = 2'd1;
    end else if (hcnt != 2'd3) begin
      hcnt_n = hcnt + 2'd1;
    end
  end

  // FIFO pointers and storage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= {in_bit, in_len};
        wptr              <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
    end
  end

  // FSM state, run counter and current run bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      rem     <= '0;
      cur_bit <= 1'b0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      cur_bit <= cur_bit_n;
    end
  end

  // Registered serial outputs; dout and history only move on emitted bits.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout     <= 1'b0;
      cen      <= 1'b0;
      run_done <= 1'b0;
      exp_run2 <= 1'b0;
      exp_run3 <= 1'b0;
      hcnt     <= 2'd0;
      busy     <= 1'b0;
    end else begin
      cen      <= emit;
      run_done <= emit && last;
      exp_run2 <= emit && (hcnt_n >= 2'd2);
      exp_run3 <= emit && (hcnt_n == 2'd3);
      busy     <= !fifo_empty || (state == S_EMIT);
      if (emit) begin
        dout <= emit_bit;
        hcnt <= hcnt_n;
      end
    end
  end

endmodule

// File: tb/tb_run_serializer.sv
// Testbench for run_serializer: directed token sequences, scoreboard of
// expected {dout, run_done, exp_run2, exp_run3} per emitted bit.
module tb_run_serializer;

  localparam int LEN_W = 4;

  logic             clk;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic [LEN_W-1:0] in_len;
  logic             stall;
  logic             dout;
  logic             cen;
  logic             run_done;
  logic             exp_run2;
  logic             exp_run3;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Scoreboard: one entry per expected emitted bit {dout, run_done, run2, run3}
  logic [3:0] exp_q[$];

  // Reference history of emitted bits
  logic       m_bit = 1'b0;
  int         m_cnt = 0;

  run_serializer #(.LEN_W(LEN_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .in_len(in_len), .stall(stall), .dout(dout), .cen(cen),
    .run_done(run_done), .exp_run2(exp_run2), .exp_run3(exp_run3), .busy(busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Append the expected bits of one token to the scoreboard.
  task automatic model_add(input logic b, input logic [LEN_W-1:0] l);
    for (int i = 0; i < int'(l); i++) begin
      if (m_cnt == 0 || b != m_bit) m_cnt = 1;
      else if (m_cnt < 3) m_cnt++;
      m_bit = b;
      exp_q.push_back({b, (i == int'(l) - 1), (m_cnt >= 2), (m_cnt >= 3)});
    end
  endtask

  // Driver: offer one token, wait (bounded) for in_ready, complete handshake.
  task automatic push_tok(input logic b, input logic [LEN_W-1:0] l);
    int waitc = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_len   = l;
    while (!in_ready && waitc < 100) begin
      tick();
      waitc++;
    end
    check("push_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    model_add(b, l);
  endtask

  task automatic drain(input int max_cycles);
    int c = 0;
    while (exp_q.size() != 0 && c < max_cycles) begin
      tick();
      c++;
    end
    tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_len   = '0;
    stall    = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_dout", dout, 0);
    check("rst_cen", cen, 0);
    check("rst_run_done", run_done, 0);
    check("rst_exp_run2", exp_run2, 0);
    check("rst_exp_run3", exp_run3, 0);
    check("rst_busy", busy, 0);
    exp_q.delete();
    m_cnt = 0;
    m_bit = 1'b0;
    resetn = 1'b1;
    tick();
  endtask

  // Monitor: compare every emitted bit with the scoreboard head; flags must
  // stay low whenever no bit is emitted.
  always @(negedge clk) begin
    logic [3:0] e;
    logic [3:0] got;
    got = {dout, run_done, exp_run2, exp_run3};
    if (cen === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: unexpected cen with dout=%0b, none expected", dout);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL sb_bit: got {dout,done,r2,r3}=%b expected %b", got, e);
        end
      end
    end else if (cen === 1'b0 && resetn === 1'b1) begin
      checks++;
      if (got[2:0] !== 3'b000) begin
        errors++;
        $display("FAIL sb_idle_flags: got {done,r2,r3}=%b expected 000", got[2:0]);
      end
    end
  end

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_len   = '0;
    stall    = 1'b0;

    // Single run (1,3): latency, run_done and busy timing
    do_reset();
    push_tok(1'b1, 4'd3);          // now in cycle t+1
    check("t1_cen_t1", cen, 0);
    tick();                        // t+2
    check("t1_cen_t2", cen, 1);
    check("t1_done_t2", run_done, 0);
    tick();                        // t+3
    check("t1_cen_t3", cen, 1);
    tick();                        // t+4
    check("t1_cen_t4", cen, 1);
    check("t1_done_t4", run_done, 1);
    check("t1_busy_t4", busy, 1);
    tick();                        // t+5
    check("t1_cen_t5", cen, 0);
    check("t1_busy_t5", busy, 0);
    check("t1_dout_hold", dout, 1);
    drain(10);

    // Back-to-back (0,2),(1,1),(0,2): 5 contiguous bits
    do_reset();
    push_tok(1'b0, 4'd2);
    push_tok(1'b1, 4'd1);
    push_tok(1'b0, 4'd2);          // now in t+3, bits at t+2..t+6
    for (int i = 0; i < 4; i++) begin
      check("t2_contig", cen, 1);
      tick();
    end
    check("t2_end", cen, 0);
    drain(10);

    // Run merge across tokens (0,2),(0,2)
    do_reset();
    push_tok(1'b0, 4'd2);
    push_tok(1'b0, 4'd2);
    drain(20);

    // Stall in the middle of (1,4)
    do_reset();
    push_tok(1'b1, 4'd4);          // t+1
    tick();                        // t+2: bit 1 visible
    stall = 1'b1;
    tick();
    check("t4_stall_cen_a", cen, 0);
    check("t4_stall_dout_a", dout, 1);
    tick();
    check("t4_stall_cen_b", cen, 0);
    check("t4_stall_dout_b", dout, 1);
    stall = 1'b0;
    drain(20);

    // FIFO full under stall; 5th token refused
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push_tok(1'b1, 4'd15);
    check("t5_full_ready", in_ready, 0);
    in_valid = 1'b1;
    in_bit   = 1'b0;
    in_len   = 4'd7;
    tick();
    check("t5_refused_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    check("t5_no_cen_stalled", cen, 0);
    stall = 1'b0;
    check("t5_ready_before_pop", in_ready, 0);
    tick();
    check("t5_ready_after_pop", in_ready, 1);
    check("t5_first_bit", cen, 1);
    drain(100);

    // Zero-length token accepted and discarded
    do_reset();
    push_tok(1'b1, 4'd0);
    for (int i = 0; i < 5; i++) begin
      check("t6_no_cen", cen, 0);
      check("t6_no_busy", busy, 0);
      tick();
    end
    drain(5);

    // Reset in the middle of (1,5)
    do_reset();
    push_tok(1'b1, 4'd5);          // t+1
    tick();                        // t+2: bit 1
    tick();                        // t+3: bit 2 visible
    resetn = 1'b0;
    tick();                        // t+4: reset applied
    check("t7_cen", cen, 0);
    check("t7_dout", dout, 0);
    check("t7_done", run_done, 0);
    check("t7_run2", exp_run2, 0);
    check("t7_run3", exp_run3, 0);
    check("t7_busy", busy, 0);
    check("t7_ready", in_ready, 1);
    check("t7_pending", exp_q.size(), 3);
    exp_q.delete();
    m_cnt = 0;
    m_bit = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t7_idle_busy", busy, 0);
    push_tok(1'b0, 4'd1);
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
